// File: rtl/sigma_xbus_arb_pkg.sv
// Shared types for the sigma system-bus arbiter: FSM states, owner index and
// the default data word returned when a read is terminated by the watchdog.
package sigma_xbus_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    typedef logic [$clog2(NUM_MASTERS)-1:0] owner_t;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hBADC0DE5;

    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t o);
        return NUM_MASTERS'(1) << o;
    endfunction

endpackage

// File: rtl/sigma_xbus_rr_pick.sv
// Combinational round-robin pick: the first requester after last_owner wins.
// Written as a scan so it generalises beyond two masters.
module sigma_xbus_rr_pick
    import sigma_xbus_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  owner_t                 last_owner_i,
    output logic                   valid_o,
    output owner_t                 winner_o
);

    int cand;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = last_owner_i;
        cand     = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = (int'(last_owner_i) + k) % NUM_MASTERS;
            if (req_i[owner_t'(cand)]) begin
                valid_o  = 1'b1;
                winner_o = owner_t'(cand);
            end
        end
    end

endmodule

// File: rtl/sigma_xbus_arb2.sv
// Two-master arbiter (CPU data port, UDM debug master) onto the sigma slave bus.
// Optional read watchdog enabled by defining SIGMA_XBUS_ARB_TIMEOUT_EN.
module sigma_xbus_arb2
    import sigma_xbus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        arst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] we_vec;
    logic [31:0]            addr_vec  [NUM_MASTERS];
    logic [3:0]             be_vec    [NUM_MASTERS];
    logic [31:0]            wdata_vec [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] ack_vec;
    logic [NUM_MASTERS-1:0] resp_vec;
    logic [31:0]            rdata_vec [NUM_MASTERS];

    assign req_vec      = {m1_req_i, m0_req_i};
    assign we_vec       = {m1_we_i, m0_we_i};
    assign addr_vec[0]  = m0_addr_i;
    assign addr_vec[1]  = m1_addr_i;
    assign be_vec[0]    = m0_be_i;
    assign be_vec[1]    = m1_be_i;
    assign wdata_vec[0] = m0_wdata_i;
    assign wdata_vec[1] = m1_wdata_i;

    arb_state_e state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_owner_q, last_owner_d;
    logic       pick_valid;
    owner_t     pick_winner;
    logic       rsp_fire;
    logic [31:0] rsp_data;
    logic       timeout_fire;

    sigma_xbus_rr_pick u_pick (
        .req_i        (req_vec),
        .last_owner_i (last_owner_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

`ifdef SIGMA_XBUS_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_expired;

    // Zero outside WAIT_RESP, so every entry starts counting from 0.
    assign tmo_cnt_d   = (state_q == ST_WAIT_RESP) ? tmo_cnt_q + CNT_W'(1) : '0;
    assign tmo_expired = (tmo_cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^{TIMEOUT_RDATA, TIMEOUT_CYCLES};
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rsp_fire     = 1'b0;
        rsp_data     = '0;
        timeout_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (s_ack_i) begin
                    last_owner_d = owner_q;
                    state_d      = we_vec[owner_q] ? ST_IDLE : ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (s_resp_i) begin
                    rsp_fire = 1'b1;
                    rsp_data = s_rdata_i;
                    state_d  = ST_IDLE;
                end
`ifdef SIGMA_XBUS_ARB_TIMEOUT_EN
                else if (tmo_expired) begin
                    rsp_fire     = 1'b1;
                    rsp_data     = TIMEOUT_RDATA;
                    timeout_fire = 1'b1;
                    state_d      = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last_owner resets to master 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= owner_t'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign s_req_o   = (state_q == ST_GRANT);
    assign s_we_o    = s_req_o & we_vec[owner_q];
    assign s_addr_o  = s_req_o ? addr_vec[owner_q]  : '0;
    assign s_be_o    = s_req_o ? be_vec[owner_q]    : '0;
    assign s_wdata_o = s_req_o ? wdata_vec[owner_q] : '0;

    assign grant_o   = (state_q == ST_IDLE) ? '0 : owner_onehot(owner_q);
    assign timeout_o = timeout_fire;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        localparam owner_t IDX = owner_t'(gi);
        assign ack_vec[gi]   = s_req_o && s_ack_i && (owner_q == IDX);
        assign resp_vec[gi]  = rsp_fire && (owner_q == IDX);
        assign rdata_vec[gi] = resp_vec[gi] ? rsp_data : '0;
    end

    assign m0_ack_o   = ack_vec[0];
    assign m1_ack_o   = ack_vec[1];
    assign m0_resp_o  = resp_vec[0];
    assign m1_resp_o  = resp_vec[1];
    assign m0_rdata_o = rdata_vec[0];
    assign m1_rdata_o = rdata_vec[1];

endmodule

// File: tb/tb_sigma_xbus_arb2.sv
// Bench for sigma_xbus_arb2: cycle vector table plus hand sequences for
// contention, async reset mid-read and (when enabled) the read watchdog.
module tb_sigma_xbus_arb2;

    localparam logic [31:0] M0_ADDR = 32'h0000_0000;
    localparam logic [31:0] M0_WD   = 32'hDEAD_BEEF;
    localparam logic [31:0] M1_ADDR = 32'h8000_0004;
    localparam logic [31:0] M1_WD   = 32'hCAFE_F00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst;
    logic        m0_req, m0_we, m0_ack, m0_resp;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_resp;
    logic [31:0] m1_rdata;
    logic        s_req, s_we, s_ack, s_resp;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic [1:0]  grant;
    logic        tmo;

    sigma_xbus_arb2 #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .arst_i(arst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(M0_ADDR), .m0_be_i(4'hF),
        .m0_wdata_i(M0_WD), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(M1_ADDR), .m1_be_i(4'h3),
        .m1_wdata_i(M1_WD), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be),
        .s_wdata_o(s_wdata), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
        .grant_o(grant), .timeout_o(tmo)
    );

    // in = {m0_req, m0_we, m1_req, m1_we, s_ack, s_resp}
    // o  = {s_req, m0_ack, m1_ack, m0_resp, m1_resp}
    typedef struct {
        logic [5:0]  in;
        logic [31:0] rd;
        logic [1:0]  push;
        logic [1:0]  g;
        logic [4:0]  o;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    typedef struct packed {
        logic [1:0]  g;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } tx_t;

    vec_t vecs [20];
    tx_t  exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;

    function automatic tx_t tx_of(input int m, input logic we);
        tx_t t;
        if (m == 0) t = '{2'b01, we, M0_ADDR, 4'hF, M0_WD};
        else        t = '{2'b10, we, M1_ADDR, 4'h3, M1_WD};
        return t;
    endfunction

    task automatic apply_in(input logic [5:0] b, input logic [31:0] rd);
        {m0_req, m0_we, m1_req, m1_we, s_ack, s_resp} = b;
        s_rdata = rd;
    endtask

    task automatic check_outs(input string name, input logic [1:0] g, input logic [4:0] o,
                              input logic [31:0] r0, input logic [31:0] r1, input logic t);
        logic [71:0] act, exp;
        act = {grant, s_req, m0_ack, m1_ack, m0_resp, m1_resp, tmo, m0_rdata, m1_rdata};
        exp = {g, o, t, r0, r1};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        tx_t act, exp;
        if (s_req && s_ack) begin
            act = {grant, s_we, s_addr, s_be, s_wdata};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL txn: unexpected transfer %h, none pending", act);
            end else begin
                exp = exp_q.pop_front();
                n_acc++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL txn: got %h want %h", act, exp);
                end else begin
                    $display("txn: grant=%b we=%b addr=%h be=%h wdata=%h ok",
                             act.g, act.we, act.addr, act.be, act.wdata);
                end
            end
        end
    endtask

    task automatic run_until(input string name, input int want, input int budget);
        n_acc = 0;
        for (int c = 0; c < budget && n_acc < want; c++) begin
            #2;
            monitor();
            @(negedge clk);
        end
        check_int(name, n_acc, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{6'b110000, 32'h0,        2'b01, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[1]  = '{6'b110010, 32'h0,        2'b00, 2'b01, 5'b11000, 32'h0,        32'h0};
        vecs[2]  = '{6'b000000, 32'h0,        2'b00, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[3]  = '{6'b001000, 32'h0,        2'b10, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[4]  = '{6'b001010, 32'h0,        2'b00, 2'b10, 5'b10100, 32'h0,        32'h0};
        vecs[5]  = '{6'b000000, 32'h0,        2'b00, 2'b10, 5'b00000, 32'h0,        32'h0};
        vecs[6]  = '{6'b000000, 32'h0,        2'b00, 2'b10, 5'b00000, 32'h0,        32'h0};
        vecs[7]  = '{6'b000001, 32'h12345678, 2'b00, 2'b10, 5'b00001, 32'h0,        32'h12345678};
        vecs[8]  = '{6'b000001, 32'hFFFFFFFF, 2'b00, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[9]  = '{6'b100000, 32'h0,        2'b01, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[10] = '{6'b100010, 32'h0,        2'b00, 2'b01, 5'b11000, 32'h0,        32'h0};
        vecs[11] = '{6'b001100, 32'h0,        2'b10, 2'b01, 5'b00000, 32'h0,        32'h0};
        vecs[12] = '{6'b001101, 32'hA5A5A5A5, 2'b00, 2'b01, 5'b00010, 32'hA5A5A5A5, 32'h0};
        vecs[13] = '{6'b001100, 32'h0,        2'b00, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[14] = '{6'b001110, 32'h0,        2'b00, 2'b10, 5'b10100, 32'h0,        32'h0};
        vecs[15] = '{6'b000000, 32'h0,        2'b00, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[16] = '{6'b110000, 32'h0,        2'b01, 2'b00, 5'b00000, 32'h0,        32'h0};
        vecs[17] = '{6'b000000, 32'h0,        2'b00, 2'b01, 5'b10000, 32'h0,        32'h0};
        vecs[18] = '{6'b110010, 32'h0,        2'b00, 2'b01, 5'b11000, 32'h0,        32'h0};
        vecs[19] = '{6'b000000, 32'h0,        2'b00, 2'b00, 5'b00000, 32'h0,        32'h0};

        // Reset state, with activity on the inputs that must not leak through.
        arst = 1'b1;
        apply_in(6'b000000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        apply_in(6'b101011, 32'hFFFFFFFF);
        #2;
        check_outs("reset", 2'b00, 5'b00000, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        apply_in(6'b000000, 32'h0);
        arst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            apply_in(vecs[i].in, vecs[i].rd);
            if (vecs[i].push[0]) exp_q.push_back(tx_of(0, vecs[i].in[4]));
            if (vecs[i].push[1]) exp_q.push_back(tx_of(1, vecs[i].in[2]));
            #2;
            check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].o, vecs[i].r0, vecs[i].r1, 1'b0);
            monitor();
            @(negedge clk);
        end
        check_int("table_pending", exp_q.size(), 0);

        // Continuous write contention after reset: strict alternation from m0.
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        for (int k = 0; k < 6; k++) exp_q.push_back(tx_of(k % 2, 1'b1));
        apply_in(6'b111110, 32'h0);
        run_until("contention_count", 6, 24);
        apply_in(6'b000000, 32'h0);
        @(negedge clk);

        // m0 read aborted by async reset while waiting for its response.
        apply_in(6'b100000, 32'h0);
        exp_q.push_back(tx_of(0, 1'b0));
        @(negedge clk);
        apply_in(6'b100010, 32'h0);
        #2;
        monitor();
        @(negedge clk);
        apply_in(6'b000000, 32'h0);
        #2;
        check_outs("rst_wait_resp", 2'b01, 5'b00000, 32'h0, 32'h0, 1'b0);
        s_resp  = 1'b1;
        s_rdata = 32'h7777_7777;
        arst    = 1'b1;
        #1;
        check_outs("rst_async", 2'b00, 5'b00000, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        arst = 1'b0;
        apply_in(6'b000000, 32'h0);
        exp_q.push_back(tx_of(0, 1'b1));
        exp_q.push_back(tx_of(1, 1'b1));
        apply_in(6'b111110, 32'h0);
        run_until("rst_tie_count", 2, 10);
        apply_in(6'b000000, 32'h0);
        @(negedge clk);

`ifdef SIGMA_XBUS_ARB_TIMEOUT_EN
        // Read that the slave never answers: watchdog fires on the 16th waiting cycle.
        apply_in(6'b001000, 32'h0);
        exp_q.push_back(tx_of(1, 1'b0));
        @(negedge clk);
        apply_in(6'b001010, 32'h0);
        #2;
        monitor();
        @(negedge clk);
        apply_in(6'b000000, 32'h0);
        for (int c = 0; c < 15; c++) begin
            #2;
            check_outs($sformatf("tmo_wait%0d", c), 2'b10, 5'b00000, 32'h0, 32'h0, 1'b0);
            @(negedge clk);
        end
        #2;
        check_outs("tmo_fire", 2'b10, 5'b00001, 32'h0, 32'hBADC0DE5, 1'b1);
        @(negedge clk);
        apply_in(6'b000001, 32'h1234_5678);
        #2;
        check_outs("tmo_stray_resp", 2'b00, 5'b00000, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        apply_in(6'b000000, 32'h0);
        @(negedge clk);
`endif

        check_int("final_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sigma_xbus_arb2.md
# sigma_xbus_arb2

Two-master arbiter for the sigma shared system bus (CPU data port and UDM debug master) to one slave-side bus (RAM/CSR interconnect). Ownership is held from grant through write acceptance or read response. Consecutive contention is resolved round-robin. An optional watchdog terminates reads that never receive a response.

## Interface
- TIMEOUT_CYCLES, 1024, cycles spent in WAIT_RESP before forced termination (used only with the timeout feature)
- TIMEOUT_RDATA, 32'hBADC0DE5, read data returned on timeout
- clk_i  in  1  system clock
- arst_i  in  1  reset, asynchronous, active-high
- m0_req_i / m1_req_i  in  1  master request
- mN_we_i  in  1  1 = write, 0 = read
- mN_addr_i  in  32  byte address
- mN_be_i  in  4  byte enables
- mN_wdata_i  in  32  write data
- mN_ack_o  out  1  request accepted (one-cycle pulse)
- mN_resp_o  out  1  read data valid (one-cycle pulse)
- mN_rdata_o  out  32  read data, valid with resp
- s_req_o, s_we_o, s_addr_o[31:0], s_be_o[3:0], s_wdata_o[31:0]  out  slave request
- s_ack_i  in  1  slave accepted request
- s_resp_i  in  1  slave read data valid
- s_rdata_i  in  32  slave read data
- grant_o  out  2  one-hot current owner, 0 when idle
- timeout_o  out  1  one-cycle pulse on forced read termination

## Operation
- FSM: IDLE, GRANT, WAIT_RESP.
- IDLE
  - Sample requests. If exactly one master requests, register it as owner.
  - If both request, pick the one not equal to last_owner and move to GRANT.
  - No request: stay in IDLE.
- GRANT
  - Slave request outputs are driven combinationally from the owner; the other master sees ack=0.
  - s_ack_i is routed to the owner's ack the same cycle.
  - On ack: if we=1, go to IDLE; if we=0, go to WAIT_RESP. In both cases last_owner <= owner.
- WAIT_RESP
  - s_req_o = 0.
  - s_resp_i and s_rdata_i are routed to the owner the same cycle, then go to IDLE.
- Masters hold req and the payload stable until ack. A request deasserted before ack is a protocol violation; the arbiter stays in GRANT.
- s_resp_i arriving in IDLE or GRANT is dropped.
- The slave must support only one outstanding read.
- Reset values: state IDLE, last_owner = master 1 (so master 0 wins the first tie), all outputs 0, timeout counter 0.
- Reset mid-transaction aborts it with no ack/resp emitted; the slave side sees s_req_o drop asynchronously.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at edge k appears on s_req_o in cycle k+1.
- Zero-wait slave (ack in the same cycle as s_req_o):
  - write occupies 2 cycles (IDLE, GRANT);
  - read occupies 2 cycles plus slave response latency (minimum 1).
- Master ack/resp are combinational pass-throughs of s_ack_i/s_resp_i; no added latency.
- Back-to-back requests from the same master with no contention: 1 idle cycle between transactions.
- Under continuous contention, grants strictly alternate.

## Configuration
- Macro: SIGMA_XBUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT_RESP entry and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES-1 without s_resp_i, the arbiter pulses owner resp with TIMEOUT_RDATA, pulses timeout_o, and goes to IDLE.
  - If s_resp_i arrives in the same cycle, the real response wins and timeout_o stays 0.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Undefined: no counter exists, WAIT_RESP waits indefinitely, and timeout_o is tied to 0.

## Structure
- Package sigma_xbus_arb_pkg holds:
  - the FSM state enum;
  - the owner index type;
  - the default TIMEOUT_RDATA constant.
- Sub-module sigma_xbus_rr_pick: a combinational 2-way round-robin pick of {req vector, last_owner} giving the winner index. Keeping it separate allows extension to N masters.
- The FSM, owner/last_owner registers, muxes and timeout counter live in the top module.

## Test plan
- m0 write to 0x00000000 with data 0xDEADBEEF, slave acks immediately -> s_req_o high exactly 1 cycle, m0_ack_o 1 pulse, grant_o 01 then 00.
- m1 read from 0x80000004, slave responds 3 cycles after ack with 0x12345678 -> m1_resp_o 1 pulse carrying 0x12345678; m0 sees no ack/resp.
- Both masters continuously request writes for 6 transactions after reset -> grant order m0, m1, m0, m1, m0, m1.
- m0 read while m1 requests during WAIT_RESP -> m1 is granted only after m0_resp_o, in the next IDLE evaluation.
- With SIGMA_XBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the slave never responds -> 16 cycles after WAIT_RESP entry, owner resp carries 0xBADC0DE5 and timeout_o pulses. A later stray s_resp_i in IDLE is dropped.
- arst_i asserted during WAIT_RESP -> all outputs 0 immediately and state IDLE. After release, a tie is granted to m0 first.
